trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter EXC_NONE, default 4'hF, SHALL be the exception code meaning "no exception".
REQ-002 Parameter CSR_MEPC, default 12'h341, SHALL be the CSR address written with the faulting PC.
REQ-003 Parameter CSR_MCAUSE, default 12'h342, SHALL be the CSR address written with the cause.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port i_clk, input, 1: rising-edge clock.
REQ-006 Port i_rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port i_exception_code_m, input, 4: exception code of the instruction in MEM; EXC_NONE means none.
REQ-008 Port i_pc_m, input, 32: PC of the instruction in MEM.
REQ-009 Port i_mret_m, input, 1: MRET in MEM.
REQ-010 Port i_stall_req, input, 1: load-use stall request from the hazard unit.
REQ-011 Ports i_mtvec and i_mepc, input, 32 each: current CSR values.
REQ-012 Ports o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en and o_mem_wb_en, output, 1 each: stage clock enables.
REQ-013 Ports o_if_id_flush, o_id_ex_flush and o_ex_mem_flush, output, 1 each: synchronous stage clears.
REQ-014 Port o_pc_sel, output, 2: PC source; 0 = sequential/branch, 1 = trap vector, 2 = MRET return.
REQ-015 Port o_redirect_pc, output, 32: target PC when o_pc_sel is nonzero.
REQ-016 Ports o_csr_wr_en (1), o_csr_addr (12) and o_csr_wdata (32), output: trap CSR write port.
REQ-017 Port o_busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, SAVE_EPC, SAVE_CAUSE and REDIRECT, with state encodings held in the package.
REQ-019 In IDLE with i_exception_code_m != EXC_NONE:
- the block SHALL latch i_pc_m and the code;
- it SHALL assert o_if_id_flush, o_id_ex_flush and o_ex_mem_flush in that same cycle;
- the next state SHALL be SAVE_EPC.
REQ-020 In SAVE_EPC:
- o_csr_wr_en SHALL be 1, o_csr_addr SHALL be CSR_MEPC and o_csr_wdata SHALL be the latched PC;
- the next state SHALL be SAVE_CAUSE.
REQ-021 In SAVE_CAUSE:
- o_csr_wr_en SHALL be 1, o_csr_addr SHALL be CSR_MCAUSE and o_csr_wdata SHALL be {28'b0, latched code};
- the next state SHALL be REDIRECT.
REQ-022 In REDIRECT:
- o_pc_sel SHALL be 1 and o_redirect_pc SHALL be {i_mtvec[31:2], 2'b00};
- o_if_id_flush SHALL be 1 and all enables SHALL be 1;
- the next state SHALL be IDLE.
REQ-023 In SAVE_EPC and SAVE_CAUSE, all five enables SHALL be 0 and o_pc_sel SHALL be 0.
REQ-024 Exception codes and MRET arriving while o_busy is high SHALL be ignored; the latched PC and code SHALL be kept.
REQ-025 In IDLE with no exception and i_mret_m = 1:
- o_pc_sel SHALL be 2 and o_redirect_pc SHALL be i_mepc;
- o_if_id_flush and o_id_ex_flush SHALL be 1;
- the FSM SHALL remain in IDLE.
REQ-026 In IDLE with no exception, no MRET and i_stall_req = 1:
- o_pc_en and o_if_id_en SHALL be 0;
- o_id_ex_flush SHALL be 1;
- all other enables SHALL be 1.
REQ-027 Priority in IDLE SHALL be exception, then MRET, then stall.
REQ-028 In IDLE with no event, all enables SHALL be 1, all flushes 0, o_pc_sel 0 and o_csr_wr_en 0.
REQ-029 All outputs SHALL be combinational decodes of the state and inputs; only the state, the latched PC and the latched code SHALL be registered.
REQ-030 A trap SHALL occupy exactly 4 cycles, detect through REDIRECT; an exception on the cycle after REDIRECT SHALL be accepted.

Reset
REQ-031 While i_rst_n = 0:
- the state SHALL be IDLE and the latched PC and code SHALL be 0;
- the outputs SHALL take their IDLE no-event values.
REQ-032 Reset asserted mid-trap SHALL abort the sequence immediately with no further CSR write.

Structure
REQ-033 A package trap_pkg SHALL hold the state encoding, EXC_NONE, the CSR addresses and the o_pc_sel encodings.
REQ-034 No sub-module SHALL be used; the FSM and output decode SHALL be a single module.

Verification
REQ-035 The bench SHALL cover the following scenarios:
- Code 4'h2 at PC 0x0000_0040, mtvec 0x0000_0105 -> flushes in cycle T; T+1 writes 0x341 <- 0x40; T+2 writes 0x342 <- 0x2; T+3 pc_sel = 1, redirect 0x104.
- MRET with i_mepc 0x0000_0080 -> same cycle: pc_sel = 2, redirect 0x80, IF/ID and ID/EX flushed, o_busy stays 0.
- i_stall_req for 2 cycles -> o_pc_en and o_if_id_en low for 2 cycles, ID/EX flushed, EX/MEM and MEM/WB enables high.
- Exception, MRET and stall in the same cycle -> trap sequence starts, no MRET redirect, no stall pattern.
- New code 4'h5 during SAVE_CAUSE -> ignored, mcause written as the original code; 4'h5 presented after REDIRECT -> new trap.
- i_rst_n low during SAVE_EPC -> state IDLE asynchronously, o_csr_wr_en 0, no mcause write after release.

Source files
------------

// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the trap controller: FSM state encoding, the default
// "no exception" code, the machine-mode CSR addresses written on a trap, and
// the encodings of the PC source select driven towards the fetch stage.
// -----------------------------------------------------------------------------
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SAVE_EPC   = 2'd1,
        ST_SAVE_CAUSE = 2'd2,
        ST_REDIRECT   = 2'd3
    } trap_state_e;

    localparam logic [3:0]  DEF_EXC_NONE   = 4'hF;
    localparam logic [11:0] DEF_CSR_MEPC   = 12'h341;
    localparam logic [11:0] DEF_CSR_MCAUSE = 12'h342;

    localparam logic [1:0]  PC_SEL_SEQ  = 2'd0;
    localparam logic [1:0]  PC_SEL_TRAP = 2'd1;
    localparam logic [1:0]  PC_SEL_MRET = 2'd2;

endpackage

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Pipeline trap sequencer. An exception seen in MEM flushes the younger
// stages, freezes the pipe while MEPC and MCAUSE are written through a
// dedicated CSR port, then redirects fetch to the trap vector. MRET and
// load-use stalls are decoded combinationally while the sequencer is idle.
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_exception_code_m [3:0]   exception code in MEM (EXC_NONE = none)
//   i_pc_m [31:0]              PC of the MEM instruction
//   i_mret_m                   MRET in MEM
//   i_stall_req                load-use stall from the hazard unit
//   i_mtvec, i_mepc [31:0]     current CSR values
//   o_pc_en .. o_mem_wb_en     stage clock enables
//   o_if_id/id_ex/ex_mem_flush synchronous stage clears
//   o_pc_sel [1:0]             0 seq/branch, 1 trap vector, 2 MRET return
//   o_redirect_pc [31:0]       target PC when o_pc_sel != 0
//   o_csr_wr_en/addr/wdata     trap CSR write port
//   o_busy                     sequencer is not idle
//
// There is no valid/ready handshake here: every output is a pure decode of
// the current state and inputs, valid in the same cycle.
// -----------------------------------------------------------------------------
module trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [3:0]  EXC_NONE   = DEF_EXC_NONE,
    parameter logic [11:0] CSR_MEPC   = DEF_CSR_MEPC,
    parameter logic [11:0] CSR_MCAUSE = DEF_CSR_MCAUSE
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_exception_code_m,
    input  logic [31:0] i_pc_m,
    input  logic        i_mret_m,
    input  logic        i_stall_req,
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    output logic        o_pc_en,
    output logic        o_if_id_en,
    output logic        o_id_ex_en,
    output logic        o_ex_mem_en,
    output logic        o_mem_wb_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_ex_mem_flush,
    output logic [1:0]  o_pc_sel,
    output logic [31:0] o_redirect_pc,
    output logic        o_csr_wr_en,
    output logic [11:0] o_csr_addr,
    output logic [31:0] o_csr_wdata,
    output logic        o_busy
);

    trap_state_e r_state;
    trap_state_e w_state_nxt;
    logic [31:0] r_pc;
    logic [3:0]  r_code;

    logic w_exc;
    logic w_take_trap;

    assign w_exc       = (i_exception_code_m != EXC_NONE);
    // Events are only accepted from IDLE; while busy they are dropped.
    assign w_take_trap = (r_state == ST_IDLE) && w_exc;

    // State and trap context registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= 32'd0;
            r_code  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take_trap) begin
                r_pc   <= i_pc_m;
                r_code <= i_exception_code_m;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_nxt    = r_state;
        o_pc_en        = 1'b1;
        o_if_id_en     = 1'b1;
        o_id_ex_en     = 1'b1;
        o_ex_mem_en    = 1'b1;
        o_mem_wb_en    = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        o_pc_sel       = PC_SEL_SEQ;
        o_redirect_pc  = 32'd0;
        o_csr_wr_en    = 1'b0;
        o_csr_addr     = 12'd0;
        o_csr_wdata    = 32'd0;
        o_busy         = (r_state != ST_IDLE);

        // Outputs are forced to their quiet idle values while reset is held,
        // so a trap in flight cannot issue another CSR write.
        if (i_rst_n) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_exc) begin
                        // Kill everything younger than the faulting instruction.
                        o_if_id_flush  = 1'b1;
                        o_id_ex_flush  = 1'b1;
                        o_ex_mem_flush = 1'b1;
                        w_state_nxt    = ST_SAVE_EPC;
                    end else if (i_mret_m) begin
                        o_pc_sel      = PC_SEL_MRET;
                        o_redirect_pc = i_mepc;
                        o_if_id_flush = 1'b1;
                        o_id_ex_flush = 1'b1;
                    end else if (i_stall_req) begin
                        // Hold PC and IF/ID, inject a bubble into ID/EX.
                        o_pc_en       = 1'b0;
                        o_if_id_en    = 1'b0;
                        o_id_ex_flush = 1'b1;
                    end
                end
                ST_SAVE_EPC: begin
                    o_pc_en     = 1'b0;
                    o_if_id_en  = 1'b0;
                    o_id_ex_en  = 1'b0;
                    o_ex_mem_en = 1'b0;
                    o_mem_wb_en = 1'b0;
                    o_csr_wr_en = 1'b1;
                    o_csr_addr  = CSR_MEPC;
                    o_csr_wdata = r_pc;
                    w_state_nxt = ST_SAVE_CAUSE;
                end
                ST_SAVE_CAUSE: begin
                    o_pc_en     = 1'b0;
                    o_if_id_en  = 1'b0;
                    o_id_ex_en  = 1'b0;
                    o_ex_mem_en = 1'b0;
                    o_mem_wb_en = 1'b0;
                    o_csr_wr_en = 1'b1;
                    o_csr_addr  = CSR_MCAUSE;
                    o_csr_wdata = {28'd0, r_code};
                    w_state_nxt = ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    // Vector base is word aligned; the mode bits are dropped.
                    o_pc_sel      = PC_SEL_TRAP;
                    o_redirect_pc = {i_mtvec[31:2], 2'b00};
                    o_if_id_flush = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  exc_code;
    logic [31:0] pc_m;
    logic        mret;
    logic        stall;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0]  pc_sel;
    logic [31:0] redirect_pc;
    logic        csr_wr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        busy;

    int n_cmp;
    int n_err;

    // Reference model context: cycles elapsed inside a trap (0 = idle)
    // plus the PC and code captured when the trap was taken.
    int          m_ph;
    logic [31:0] m_pc;
    logic [3:0]  m_code;

    trap_ctrl dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_exception_code_m (exc_code),
        .i_pc_m             (pc_m),
        .i_mret_m           (mret),
        .i_stall_req        (stall),
        .i_mtvec            (mtvec),
        .i_mepc             (mepc),
        .o_pc_en            (pc_en),
        .o_if_id_en         (if_id_en),
        .o_id_ex_en         (id_ex_en),
        .o_ex_mem_en        (ex_mem_en),
        .o_mem_wb_en        (mem_wb_en),
        .o_if_id_flush      (if_id_flush),
        .o_id_ex_flush      (id_ex_flush),
        .o_ex_mem_flush     (ex_mem_flush),
        .o_pc_sel           (pc_sel),
        .o_redirect_pc      (redirect_pc),
        .o_csr_wr_en        (csr_wr_en),
        .o_csr_addr         (csr_addr),
        .o_csr_wdata        (csr_wdata),
        .o_busy             (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  en_vec;
    logic [2:0]  fl_vec;
    logic [87:0] dut_vec;
    assign en_vec  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign fl_vec  = {if_id_flush, id_ex_flush, ex_mem_flush};
    assign dut_vec = {en_vec, fl_vec, pc_sel, redirect_pc, csr_wr_en, csr_addr, csr_wdata, busy};

    // Expected outputs from the behavioural rules: a trap is a fixed
    // 4-cycle sequence, idle events resolve exception > MRET > stall.
    function automatic logic [87:0] model_out(input int ph, input logic rst,
                                              input logic [3:0] code, input logic mr,
                                              input logic st, input logic [31:0] tv,
                                              input logic [31:0] ep, input logic [31:0] spc,
                                              input logic [3:0] scode);
        logic [4:0]  en;
        logic [2:0]  fl;
        logic [1:0]  sel;
        logic [31:0] rd;
        logic        wr;
        logic [11:0] ad;
        logic [31:0] wd;
        logic        bz;
        en = 5'b11111; fl = 3'b000; sel = 2'd0; rd = 32'd0;
        wr = 1'b0; ad = 12'd0; wd = 32'd0; bz = 1'b0;
        if (rst) begin
            bz = (ph != 0);
            if (ph == 0) begin
                if (code != 4'hF) fl = 3'b111;
                else if (mr) begin sel = 2'd2; rd = ep; fl = 3'b110; end
                else if (st) begin en = 5'b00111; fl = 3'b010; end
            end else if (ph == 1) begin
                en = 5'b00000; wr = 1'b1; ad = 12'h341; wd = spc;
            end else if (ph == 2) begin
                en = 5'b00000; wr = 1'b1; ad = 12'h342; wd = 32'(scode);
            end else begin
                sel = 2'd1; rd = tv - (tv % 4); fl = 3'b100;
            end
        end
        return {en, fl, sel, rd, wr, ad, wd, bz};
    endfunction

    // driver tasks
    task automatic drive(input logic [3:0] c, input logic [31:0] p, input logic mr, input logic st);
        @(negedge clk);
        exc_code = c; pc_m = p; mret = mr; stall = st;
        #1;
    endtask

    // Advance one rising edge and step the model with the inputs seen there.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_ph = 0; m_pc = 0; m_code = 0;
        end else if (m_ph == 0) begin
            if (exc_code != 4'hF) begin
                m_ph = 1; m_pc = pc_m; m_code = exc_code;
            end
        end else begin
            m_ph = (m_ph + 1) % 4;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        exc_code = 4'h2; pc_m = 32'h1234; mret = 1'b1; stall = 1'b1;
        mtvec = 32'h0; mepc = 32'h0;
        m_ph = 0; m_pc = 0; m_code = 0;
        #7;
        n_cmp++;
        if (dut_vec !== {5'b11111, 3'b000, 2'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected idle no-event", dut_vec);
        end
        tick(); tick();
        drive(4'hF, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (en_vec !== 5'b11111 || fl_vec !== 3'b000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: en=%b fl=%b busy=%b expected 11111/000/0", en_vec, fl_vec, busy);
        end
        tick();
    endtask

    task automatic test_trap();
        mtvec = 32'h0000_0105;
        drive(4'h2, 32'h0000_0040, 1'b0, 1'b0);
        n_cmp++;
        if (fl_vec !== 3'b111 || busy !== 1'b0 || csr_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL trap_detect: fl=%b busy=%b wr=%b expected 111/0/0", fl_vec, busy, csr_wr_en);
        end
        tick();
        drive(4'hF, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (csr_wr_en !== 1'b1 || csr_addr !== 12'h341 || csr_wdata !== 32'h40 ||
            en_vec !== 5'b00000 || pc_sel !== 2'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL trap_mepc: wr=%b addr=%h data=%h en=%b sel=%0d busy=%b expected 1/341/40/00000/0/1",
                     csr_wr_en, csr_addr, csr_wdata, en_vec, pc_sel, busy);
        end
        tick();
        drive(4'hF, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (csr_wr_en !== 1'b1 || csr_addr !== 12'h342 || csr_wdata !== 32'h2 || en_vec !== 5'b00000) begin
            n_err++;
            $display("FAIL trap_mcause: wr=%b addr=%h data=%h en=%b expected 1/342/2/00000",
                     csr_wr_en, csr_addr, csr_wdata, en_vec);
        end
        tick();
        drive(4'hF, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (pc_sel !== 2'd1 || redirect_pc !== 32'h104 || if_id_flush !== 1'b1 ||
            en_vec !== 5'b11111 || csr_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL trap_redirect: sel=%0d pc=%h flush=%b en=%b wr=%b expected 1/104/1/11111/0",
                     pc_sel, redirect_pc, if_id_flush, en_vec, csr_wr_en);
        end
        tick();
        drive(4'hF, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (busy !== 1'b0 || pc_sel !== 2'd0) begin
            n_err++;
            $display("FAIL trap_done: busy=%b sel=%0d expected 0/0", busy, pc_sel);
        end
        tick();
    endtask

    task automatic test_mret();
        mepc = 32'h0000_0080;
        drive(4'hF, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (pc_sel !== 2'd2 || redirect_pc !== 32'h80 || fl_vec !== 3'b110 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mret_redirect: sel=%0d pc=%h fl=%b busy=%b expected 2/80/110/0",
                     pc_sel, redirect_pc, fl_vec, busy);
        end
        tick();
        drive(4'hF, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (busy !== 1'b0 || pc_sel !== 2'd0) begin
            n_err++;
            $display("FAIL mret_after: busy=%b sel=%0d expected 0/0", busy, pc_sel);
        end
        tick();
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            drive(4'hF, 32'h0, 1'b0, 1'b1);
            n_cmp++;
            if (en_vec !== 5'b00111 || fl_vec !== 3'b010 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL stall_cycle%0d: en=%b fl=%b busy=%b expected 00111/010/0", i, en_vec, fl_vec, busy);
            end
            tick();
        end
        drive(4'hF, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (en_vec !== 5'b11111 || fl_vec !== 3'b000) begin
            n_err++;
            $display("FAIL stall_release: en=%b fl=%b expected 11111/000", en_vec, fl_vec);
        end
        tick();
    endtask

    task automatic test_priority();
        mtvec = 32'h0000_1000; mepc = 32'h0000_2000;
        drive(4'h3, 32'h0000_0500, 1'b1, 1'b1);
        n_cmp++;
        if (pc_sel !== 2'd0 || en_vec !== 5'b11111 || fl_vec !== 3'b111) begin
            n_err++;
            $display("FAIL prio_detect: sel=%0d en=%b fl=%b expected 0/11111/111", pc_sel, en_vec, fl_vec);
        end
        tick();
        drive(4'hF, 32'h0, 1'b1, 1'b1);
        n_cmp++;
        if (busy !== 1'b1 || csr_addr !== 12'h341 || csr_wdata !== 32'h500 || pc_sel !== 2'd0) begin
            n_err++;
            $display("FAIL prio_mepc: busy=%b addr=%h data=%h sel=%0d expected 1/341/500/0",
                     busy, csr_addr, csr_wdata, pc_sel);
        end
        tick();
        drive(4'hF, 32'h0, 1'b0, 1'b0);
        tick();
        drive(4'hF, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_ignore_busy();
        mtvec = 32'h0000_0300;
        drive(4'h7, 32'h0000_0200, 1'b0, 1'b0);
        tick();
        drive(4'h9, 32'h0000_0aaa, 1'b1, 1'b0);
        n_cmp++;
        if (csr_addr !== 12'h341 || csr_wdata !== 32'h200 || pc_sel !== 2'd0) begin
            n_err++;
            $display("FAIL busy_ignore_epc: addr=%h data=%h sel=%0d expected 341/200/0", csr_addr, csr_wdata, pc_sel);
        end
        tick();
        drive(4'h5, 32'h0000_0bbb, 1'b0, 1'b0);
        n_cmp++;
        if (csr_addr !== 12'h342 || csr_wdata !== 32'h7) begin
            n_err++;
            $display("FAIL busy_ignore_cause: addr=%h data=%h expected 342/7", csr_addr, csr_wdata);
        end
        tick();
        drive(4'h5, 32'h0000_0ccc, 1'b0, 1'b0);
        n_cmp++;
        if (pc_sel !== 2'd1 || redirect_pc !== 32'h300 || ex_mem_flush !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ignore_redir: sel=%0d pc=%h exflush=%b expected 1/300/0", pc_sel, redirect_pc, ex_mem_flush);
        end
        tick();
        drive(4'h5, 32'h0000_0444, 1'b0, 1'b0);
        n_cmp++;
        if (fl_vec !== 3'b111 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_back_detect: fl=%b busy=%b expected 111/0", fl_vec, busy);
        end
        tick();
        drive(4'hF, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (csr_addr !== 12'h341 || csr_wdata !== 32'h444) begin
            n_err++;
            $display("FAIL back_to_back_epc: addr=%h data=%h expected 341/444", csr_addr, csr_wdata);
        end
        tick();
        drive(4'hF, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (csr_wdata !== 32'h5) begin
            n_err++;
            $display("FAIL back_to_back_cause: data=%h expected 5", csr_wdata);
        end
        tick();
        drive(4'hF, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_trap();
        drive(4'h6, 32'h0000_0600, 1'b0, 1'b0);
        tick();
        #2;
        drive(4'hF, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        m_ph = 0; m_pc = 0; m_code = 0;
        #1;
        n_cmp++;
        if (csr_wr_en !== 1'b0 || busy !== 1'b0 || en_vec !== 5'b11111) begin
            n_err++;
            $display("FAIL reset_mid_trap: wr=%b busy=%b en=%b expected 0/0/11111", csr_wr_en, busy, en_vec);
        end
        tick();
        drive(4'hF, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (csr_wr_en !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_no_write%0d: wr=%b busy=%b expected 0/0", i, csr_wr_en, busy);
            end
            tick();
            drive(4'hF, 32'h0, 1'b0, 1'b0);
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0]  c;
        logic [87:0] exp_v;
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            mtvec = $urandom;
            mepc  = $urandom;
            drive(c, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            exp_v = model_out(m_ph, rst_n, exc_code, mret, stall, mtvec, mepc, m_pc, m_code);
            n_cmp++;
            if (dut_vec !== exp_v) begin
                n_err++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_trap();
        test_mret();
        test_stall();
        test_priority();
        test_ignore_busy();
        test_reset_mid_trap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
